// File: rtl/reflector_cfg.sv
// Programmable involutive substitution table (reflector / plugboard) with pairwise
// config commands, post-change validity scan and one registered lookup per cycle.
module reflector_cfg #(
  parameter int unsigned N         = 26,
  parameter int unsigned W         = 5,
  parameter bit          REFLECTOR = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cfg_valid_i,
  output logic         cfg_ready_o,
  input  logic [1:0]   cfg_op_i,
  input  logic [W-1:0] cfg_a_i,
  input  logic [W-1:0] cfg_b_i,
  output logic         cfg_err_o,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  output logic         out_err_o,
  output logic         table_ok_o,
  output logic [W:0]   fixed_cnt_o
);

  localparam int unsigned CW = W + 1;

  localparam logic [1:0] OP_PAIR   = 2'b00;
  localparam logic [1:0] OP_UNPAIR = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_CHECK  = 2'b11;

  typedef enum logic [2:0] {IDLE, BRK, LNK, CLR, CHK} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    tbl_q [N];
  logic [W-1:0]    tbl_d [N];
  logic [W-1:0]    a_q, a_d, b_q, b_d, pa_q, pa_d, pb_q, pb_d;
  logic [1:0]      op_q, op_d;
  logic [W-1:0]    idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            inv_q, inv_d;
  logic [CW-1:0]   fixed_q, fixed_d;
  logic            ok_q, ok_d;
  logic            ready_q, ready_d;
  logic            cfg_err_q, cfg_err_d;
  logic            out_valid_q, out_valid_d;
  logic            out_err_q, out_err_d;
  logic [W-1:0]    out_data_q, out_data_d;

  logic            cfg_fire, lk_fire, lk_oor, a_oor, b_oor, reject;
  logic [W-1:0]    scan_e;
  logic            scan_self, scan_inv;
  logic [CW-1:0]   cnt_inc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      for (int i = 0; i < int'(N); i++) tbl_q[i] <= W'(i);
      a_q         <= '0;
      b_q         <= '0;
      pa_q        <= '0;
      pb_q        <= '0;
      op_q        <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      inv_q       <= 1'b0;
      fixed_q     <= CW'(N);
      ok_q        <= !REFLECTOR;
      ready_q     <= 1'b1;
      cfg_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      tbl_q       <= tbl_d;
      a_q         <= a_d;
      b_q         <= b_d;
      pa_q        <= pa_d;
      pb_q        <= pb_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      inv_q       <= inv_d;
      fixed_q     <= fixed_d;
      ok_q        <= ok_d;
      ready_q     <= ready_d;
      cfg_err_q   <= cfg_err_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tbl_d       = tbl_q;
    a_d         = a_q;
    b_d         = b_q;
    pa_d        = pa_q;
    pb_d        = pb_q;
    op_d        = op_q;
    idx_d       = '0;
    cnt_d       = '0;
    inv_d       = 1'b0;
    fixed_d     = fixed_q;
    ok_d        = ok_q;
    cfg_err_d   = 1'b0;

    cfg_fire    = cfg_valid_i & ready_q;
    lk_fire     = in_valid_i & ready_q;
    a_oor       = 32'(cfg_a_i) >= N;
    b_oor       = 32'(cfg_b_i) >= N;
    lk_oor      = 32'(in_data_i) >= N;
    reject      = ((cfg_op_i == OP_PAIR) && (a_oor || b_oor || (cfg_a_i == cfg_b_i)))
               || ((cfg_op_i == OP_UNPAIR) && a_oor);

    // Lookups always see the table as it stood before this cycle's writes
    out_valid_d = lk_fire;
    out_err_d   = lk_fire & lk_oor;
    out_data_d  = out_data_q;
    if (lk_fire) out_data_d = lk_oor ? in_data_i : tbl_q[in_data_i];

    scan_e      = tbl_q[idx_q];
    scan_self   = (scan_e == idx_q);
    scan_inv    = (tbl_q[scan_e] != idx_q);
    cnt_inc     = cnt_q + CW'(scan_self);

    unique case (state_q)
      IDLE: begin
        if (cfg_fire) begin
          if (reject) begin
            cfg_err_d = 1'b1;
          end else begin
            a_d  = cfg_a_i;
            b_d  = cfg_b_i;
            op_d = cfg_op_i;
            pa_d = a_oor ? cfg_a_i : tbl_q[cfg_a_i];
            pb_d = b_oor ? cfg_b_i : tbl_q[cfg_b_i];
            ok_d = 1'b0;
            unique case (cfg_op_i)
              OP_PAIR, OP_UNPAIR: state_d = BRK;
              OP_CLEAR:           state_d = CLR;
              OP_CHECK:           state_d = CHK;
              default:            state_d = IDLE;
            endcase
          end
        end
      end
      BRK: begin
        // Release old partners before linking so no stale half-pair survives
        if (op_q == OP_PAIR) begin
          tbl_d[pa_q] = pa_q;
          tbl_d[pb_q] = pb_q;
          state_d     = LNK;
        end else begin
          tbl_d[a_q]  = a_q;
          tbl_d[pa_q] = pa_q;
          state_d     = CHK;
        end
      end
      LNK: begin
        tbl_d[a_q] = b_q;
        tbl_d[b_q] = a_q;
        state_d    = CHK;
      end
      CLR: begin
        for (int i = 0; i < int'(N); i++) tbl_d[i] = W'(i);
        state_d = CHK;
      end
      CHK: begin
        cnt_d = cnt_inc;
        inv_d = inv_q | scan_inv;
        idx_d = idx_q + W'(1);
        if (idx_q == W'(N - 1)) begin
          fixed_d = cnt_inc;
          ok_d    = !(inv_q | scan_inv) && (!REFLECTOR || (cnt_inc == '0));
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  assign cfg_ready_o = ready_q;
  assign in_ready_o  = ready_q;
  assign cfg_err_o   = cfg_err_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_err_o   = out_err_q;
  assign table_ok_o  = ok_q;
  assign fixed_cnt_o = fixed_q;

endmodule

// File: tb/tb_reflector_cfg.sv
// Directed self-checking bench for reflector_cfg (N=26, W=5, reflector mode).
module tb_reflector_cfg;

  localparam int unsigned N = 26;
  localparam int unsigned W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_valid, cfg_ready, cfg_err;
  logic [1:0]   cfg_op;
  logic [W-1:0] cfg_a, cfg_b;
  logic         in_valid, in_ready, out_valid, out_err, table_ok;
  logic [W-1:0] in_data, out_data;
  logic [W:0]   fixed_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  reflector_cfg #(.N(N), .W(W), .REFLECTOR(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_op_i(cfg_op),
    .cfg_a_i(cfg_a), .cfg_b_i(cfg_b), .cfg_err_o(cfg_err),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_err_o(out_err),
    .table_ok_o(table_ok), .fixed_cnt_o(fixed_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Edges elapsed until cfg_ready is seen high, bounded
  task automatic wait_ready(output int n);
    n = 0;
    while (!cfg_ready && n < 200) begin
      tick();
      n++;
    end
    if (!cfg_ready) check("ready_timeout", 32'(cfg_ready), 32'd1);
  endtask

  task automatic cfg_cmd(input logic [1:0] op, input int a, input int b);
    int n;
    wait_ready(n);
    cfg_valid = 1'b1;
    cfg_op    = op;
    cfg_a     = W'(a);
    cfg_b     = W'(b);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic lookup(input string tag, input int d, input int exp_d, input bit exp_e);
    int n;
    wait_ready(n);
    in_valid = 1'b1;
    in_data  = W'(d);
    tick();
    in_valid = 1'b0;
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_dat"}, 32'(out_data), 32'(exp_d));
    check({tag, "_err"}, 32'(out_err), 32'(exp_e));
  endtask

  int pa_tab [13] = '{0, 1, 2, 4, 5, 6, 7, 10, 11, 12, 13, 17, 21};
  int pb_tab [13] = '{23, 3, 19, 25, 14, 9, 8, 22, 15, 16, 20, 18, 24};

  initial begin
    int n;
    rst = 1'b1; cfg_valid = 1'b0; cfg_op = '0; cfg_a = '0; cfg_b = '0;
    in_valid = 1'b0; in_data = '0;

    // Reset state and identity lookup
    do_reset();
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_fixed", 32'(fixed_cnt), 32'd26);
    check("rst_ok", 32'(table_ok), 32'd0);
    check("rst_outv", 32'(out_valid), 32'd0);
    check("rst_cerr", 32'(cfg_err), 32'd0);
    lookup("id7", 7, 7, 1'b0);
    tick();
    check("outv_idle", 32'(out_valid), 32'd0);

    // Single pair and busy window
    cfg_cmd(2'b00, 0, 23);
    check("pair_busy", 32'(in_ready), 32'd0);
    wait_ready(n);
    check("pair_lat", 32'(n + 1), 32'd29);
    lookup("p0", 0, 23, 1'b0);
    lookup("p23", 23, 0, 1'b0);
    check("pair_fixed", 32'(fixed_cnt), 32'd24);

    // Re-pairing breaks the previous partner
    cfg_cmd(2'b00, 0, 5);
    lookup("r0", 0, 5, 1'b0);
    lookup("r5", 5, 0, 1'b0);
    lookup("r23", 23, 23, 1'b0);
    check("re_fixed", 32'(fixed_cnt), 32'd24);

    // Full reflector wiring
    for (int i = 0; i < 13; i++) cfg_cmd(2'b00, pa_tab[i], pb_tab[i]);
    wait_ready(n);
    check("full_ok", 32'(table_ok), 32'd1);
    check("full_fixed", 32'(fixed_cnt), 32'd0);
    lookup("f7", 7, 8, 1'b0);
    lookup("f8", 8, 7, 1'b0);
    lookup("f17", 17, 18, 1'b0);
    lookup("f18", 18, 17, 1'b0);

    // Unpair one letter
    cfg_cmd(2'b01, 8, 0);
    check("unp_okclr", 32'(table_ok), 32'd0);
    wait_ready(n);
    check("unp_lat", 32'(n + 1), 32'd28);
    lookup("u7", 7, 7, 1'b0);
    lookup("u8", 8, 8, 1'b0);
    check("unp_ok", 32'(table_ok), 32'd0);
    check("unp_fixed", 32'(fixed_cnt), 32'd2);

    // Restore a valid table, then rejected commands must leave it alone
    cfg_cmd(2'b00, 7, 8);
    wait_ready(n);
    check("rest_ok", 32'(table_ok), 32'd1);
    cfg_cmd(2'b00, 4, 4);
    check("rej44_err", 32'(cfg_err), 32'd1);
    check("rej44_rdy", 32'(cfg_ready), 32'd1);
    check("rej44_ok", 32'(table_ok), 32'd1);
    tick();
    check("rej44_pulse", 32'(cfg_err), 32'd0);
    lookup("rej4", 4, 25, 1'b0);
    cfg_cmd(2'b00, 3, 26);
    check("rej26_err", 32'(cfg_err), 32'd1);
    check("rej26_ok", 32'(table_ok), 32'd1);
    lookup("rej3", 3, 1, 1'b0);
    cfg_cmd(2'b01, 31, 0);
    check("rej31_err", 32'(cfg_err), 32'd1);
    check("rej31_rdy", 32'(cfg_ready), 32'd1);
    check("rej_fixed", 32'(fixed_cnt), 32'd0);
    lookup("oor30", 30, 30, 1'b1);

    // Simultaneous config and lookup: lookup sees pre-write table
    do_reset();
    cfg_valid = 1'b1; cfg_op = 2'b00; cfg_a = W'(1); cfg_b = W'(3);
    in_valid = 1'b1; in_data = W'(1);
    tick();
    cfg_valid = 1'b0; in_valid = 1'b0;
    check("sim_vld", 32'(out_valid), 32'd1);
    check("sim_dat", 32'(out_data), 32'd1);
    check("sim_busy", 32'(cfg_ready), 32'd0);
    lookup("sim_after", 1, 3, 1'b0);

    // Reset in the middle of a scan
    cfg_cmd(2'b11, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    check("chk_busy", 32'(cfg_ready), 32'd0);
    do_reset();
    check("mid_ready", 32'(cfg_ready), 32'd1);
    check("mid_fixed", 32'(fixed_cnt), 32'd26);
    check("mid_ok", 32'(table_ok), 32'd0);
    lookup("mid1", 1, 1, 1'b0);
    lookup("mid3", 3, 3, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/reflector_cfg.md
Name: reflector_cfg

Overview:
- Programmable, parametrised successor to the fixed-wiring lampboard/reflector substitution.
- Holds an N-entry involutive substitution table (index <-> partner), programmed pair-by-pair over a config handshake.
- Scans the table after every change to flag validity and count self-mapped letters.
- Serves one registered lookup per cycle; used as reflector (no self-mapped letters allowed) or plugboard (self-mapped letters allowed).

Parameters:
- N, 26, alphabet size; 2 <= N <= 2^W.
- W, 5, letter index width.
- REFLECTOR, 1, 1 = any self-mapped letter makes table invalid; 0 = plugboard mode, self-mapped letters legal.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- cfg_valid  in  1  config command present.
- cfg_ready  out  1  high only in IDLE; command accepted when cfg_valid & cfg_ready.
- cfg_op  in  2  00 PAIR, 01 UNPAIR, 10 CLEAR, 11 CHECK.
- cfg_a  in  W  first letter (PAIR/UNPAIR).
- cfg_b  in  W  second letter (PAIR only).
- cfg_err  out  1  one-cycle pulse, command rejected.
- in_valid  in  1  lookup request.
- in_ready  out  1  equals cfg_ready.
- in_data  in  W  letter to substitute.
- out_valid  out  1  lookup result valid; no backpressure.
- out_data  out  W  substituted letter.
- out_err  out  1  qualifies out_valid; in_data was >= N.
- table_ok  out  1  table is a valid involution for the selected mode.
- fixed_cnt  out  W+1  number of self-mapped entries from the last scan.

Behaviour:
- Reset values:
  - table[i] = i for all i; state IDLE; cfg_ready/in_ready = 1.
  - cfg_err, out_valid, out_err, out_data = 0.
  - fixed_cnt = N; table_ok = !REFLECTOR.
- Reset mid-operation aborts the command and applies the same reset values.
- FSM states: IDLE, BRK, LNK, CLR, CHK.
- Command accept cycle T (IDLE): latch a, b, pa = table[a], pb = table[b]; clear table_ok.
- PAIR: T+1 BRK writes table[pa] = pa and table[pb] = pb. T+2 LNK writes table[a] = b and table[b] = a; LNK writes win over BRK values. Then CHK.
- UNPAIR: T+1 BRK writes table[a] = a and table[pa] = pa. Then CHK.
- CLEAR: T+1 CLR writes identity to all entries. Then CHK.
- CHECK: CHK immediately from T+1.
- CHK scans one index per cycle for N cycles, i = 0..N-1:
  - counts table[i] == i;
  - sets inv_err if table[table[i]] != i.
- On the last CHK cycle:
  - fixed_cnt <= count;
  - table_ok <= !inv_err && (REFLECTOR ? count == 0 : 1);
  - return to IDLE.
- Cycle when IDLE/cfg_ready is high again: PAIR T+3+N, UNPAIR and CLEAR T+2+N, CHECK T+1+N.
- Rejection conditions:
  - a >= N (PAIR/UNPAIR);
  - b >= N (PAIR);
  - a == b (PAIR).
- A rejected command is consumed: cfg_err = 1 at T+1, no table or table_ok change, FSM stays IDLE.
- Lookup accepted when in_valid & in_ready. At the next cycle:
  - out_valid = 1;
  - if in_data < N: out_data = table[in_data], out_err = 0;
  - else out_data = in_data, out_err = 1.
- out_valid = 0 in any cycle without an accepted lookup.
- Lookups are served regardless of table_ok.
- Simultaneous cfg and lookup accept in IDLE: both taken; the lookup uses the table contents before the command's writes.
- in_ready = 0 in BRK/LNK/CLR/CHK; requests are held off, not dropped.

Test Plan (N=26, W=5, REFLECTOR=1):
- Reset, lookup 7 -> next cycle out_valid=1, out_data=7; fixed_cnt=26, table_ok=0, cfg_ready=1.
- PAIR(0,23) -> cfg_ready low 28 cycles, high at T+29; lookups 0->23, 23->0; fixed_cnt=24.
- PAIR(0,23) then PAIR(0,5) -> 0->5, 5->0, 23->23; fixed_cnt=24.
- PAIR all 13 pairs AX BD CT EZ FO GJ HI KW LP MQ NU RS VY:
  - expect table_ok=1, fixed_cnt=0;
  - lookups 7->8, 8->7, 17->18, 18->17;
  - then UNPAIR(8) -> 7->7, 8->8, table_ok=0, fixed_cnt=2.
- Rejections:
  - PAIR(4,4), PAIR(3,26), UNPAIR(31) -> each gives cfg_err pulse at T+1, table and table_ok unchanged;
  - lookup 30 -> out_err=1, out_data=30.
- PAIR(1,3) with lookup 1 in same cycle -> out_data=1.
- Reset asserted during CHK -> identity table, fixed_cnt=26, cfg_ready=1 the cycle after reset deasserts.
